// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Contents: access-size encodings, FSM state type, alignment check.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Half needs addr[0]==0, word needs addr[1:0]==0; byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-lane steering between the 32-bit array word and right-aligned core data.
// Ports:
//   size_i     access size (byte/half/word; 2'b11 leaves the word untouched)
//   off_i      byte offset within the word (addr[1:0])
//   wdata_i    right-aligned store data
//   old_word_i current array word
//   wword_o    old word with the store lanes replaced
//   rdata_o    load data, right-aligned and zero-extended
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;

  assign byte_sh = {off_i, 3'b000};
  assign half_sh = {off_i[1], 4'b0000};

  // Merge store lanes into the old word and extract the aligned load value.
  always_comb begin
    wword_o = old_word_i;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        wword_o[byte_sh +: 8] = wdata_i[7:0];
        rdata_o               = {24'b0, old_word_i[byte_sh +: 8]};
      end
      SZ_HALF: begin
        wword_o[half_sh +: 16] = wdata_i[15:0];
        rdata_o                = {16'b0, old_word_i[half_sh +: 16]};
      end
      SZ_WORD: begin
        wword_o = wdata_i;
        rdata_o = old_word_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with programmable
// wait states, lane-masked stores, zero-extended loads and error flagging.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i, we_i          request valid, 1 = store
//   size_i, addr_i       funct3 size (bit 2 ignored), byte address
//   wdata_i              right-aligned store data
//   ready_o              request can be accepted this cycle
//   rvalid_o             one-cycle response strobe
//   rdata_o, err_o       load data / error flag, valid with rvalid_o
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INI = 4'(WAIT_CYCLES);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept_c;
  logic        commit_c;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] rel_addr;
  logic [IDX_W-1:0] idx;
  logic        acc_err;
  logic [31:0] old_word;
  logic [31:0] wword;
  logic [31:0] lane_rdata;
  logic        unused_size;

  assign unused_size = size_i[2];

  // With zero wait states the commit edge is the accept edge, so the live
  // request is used instead of the latched copy.
  assign cur_we    = (state_q == IDLE) ? we_i        : we_q;
  assign cur_size  = (state_q == IDLE) ? size_i[1:0] : size_q;
  assign cur_addr  = (state_q == IDLE) ? addr_i      : addr_q;
  assign cur_wdata = (state_q == IDLE) ? wdata_i     : wdata_q;

  // Addresses below BASE_ADDR wrap to large values and fail the range test.
  assign rel_addr = cur_addr - BASE_ADDR;
  assign idx      = rel_addr[IDX_W+1:2];
  assign acc_err  = (cur_size == 2'b11) || is_misaligned(cur_size, cur_addr[1:0])
                    || (rel_addr >= SPAN);
  assign old_word = mem[idx];

  dmem_lane_mux u_lane_mux (
    .size_i     (cur_size),
    .off_i      (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .old_word_i (old_word),
    .wword_o    (wword),
    .rdata_o    (lane_rdata)
  );

  // State register and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_INI;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs and commit strobe.
  always_comb begin
    ready_o  = (state_q == IDLE) && !rst_i;
    accept_c = req_i && ready_o;
    commit_c = (state_d == RESP) && (state_q != RESP) && !rst_i;
  end

  // Request capture on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= we_i;
      size_q  <= size_i[1:0];
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (commit_c && cur_we && !acc_err) begin
      mem[idx] <= wword;
    end
  end

  // Response registers are loaded on the commit edge and zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= commit_c;
      err_q    <= commit_c && acc_err;
      rdata_q  <= (commit_c && !acc_err && !cur_we) ? lane_rdata : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders with WAIT_CYCLES 0, 3 and 2 on a shared clock.
module tb_dmem_responder;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [2:0]  size   [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        ready  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  dmem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  dmem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .we_i(we[2]), .size_i(size[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .ready_o(ready[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // One request: drive at a negedge, count negedges until rvalid, check response.
  task automatic txn(input int k, input string name, input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                     input logic exp_err, input logic check_rd, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    chk({name, " ready"}, 32'(ready[k]), 32'd1);
    req[k] = 1'b1; we[k] = w; size[k] = sz; addr[k] = a; wdata[k] = wd;
    @(negedge clk);
    req[k] = 1'b0;
    lat = 1;
    while (rvalid[k] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " err"}, 32'(err[k]), 32'(exp_err));
    if (check_rd) chk({name, " rdata"}, rdata[k], exp_rd);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; size[k] = 3'b000;
      addr[k] = 32'h0; wdata[k] = 32'h0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst ready", 32'(ready[k]), 32'd0);
      chk("rst rvalid", 32'(rvalid[k]), 32'd0);
      chk("rst err", 32'(err[k]), 32'd0);
      chk("rst rdata", rdata[k], 32'd0);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Zero wait states: basic store/load and lane handling
    txn(0, "st DEADBEEF", 1'b1, SW, 32'h2000, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0);
    txn(0, "ld word", 1'b0, SW, 32'h2000, 32'h0, 1, 1'b0, 1'b1, 32'hDEADBEEF);
    txn(0, "st 11223344", 1'b1, SW, 32'h2000, 32'h11223344, 1, 1'b0, 1'b0, 32'h0);
    txn(0, "st byte 5A", 1'b1, SB, 32'h2001, 32'hABCDEF5A, 1, 1'b0, 1'b0, 32'h0);
    txn(0, "ld merged", 1'b0, SW, 32'h2000, 32'h0, 1, 1'b0, 1'b1, 32'h11225A44);
    txn(0, "ld byte 2001", 1'b0, 3'b100, 32'h2001, 32'h0, 1, 1'b0, 1'b1, 32'h0000005A);
    txn(0, "ld half 2002", 1'b0, SH, 32'h2002, 32'h0, 1, 1'b0, 1'b1, 32'h00001122);
    txn(0, "st half BEEF", 1'b1, SH, 32'h2002, 32'h1234BEEF, 1, 1'b0, 1'b0, 32'h0);
    txn(0, "ld half 2000", 1'b0, SH, 32'h2000, 32'h0, 1, 1'b0, 1'b1, 32'h00005A44);
    txn(0, "ld byte 2003", 1'b0, SB, 32'h2003, 32'h0, 1, 1'b0, 1'b1, 32'h000000BE);
    txn(0, "st last word", 1'b1, SW, 32'h2FFC, 32'h0F0F0F0F, 1, 1'b0, 1'b0, 32'h0);
    txn(0, "ld last word", 1'b0, SW, 32'h2FFC, 32'h0, 1, 1'b0, 1'b1, 32'h0F0F0F0F);

    // Error cases
    txn(0, "err half 2003", 1'b0, SH, 32'h2003, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn(0, "err st w 2002", 1'b1, SW, 32'h2002, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'h0);
    txn(0, "err ld 3000", 1'b0, SW, 32'h3000, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn(0, "err ld 1FFC", 1'b0, SW, 32'h1FFC, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn(0, "err size 011", 1'b0, 3'b011, 32'h2000, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn(0, "ld unchanged", 1'b0, SW, 32'h2000, 32'h0, 1, 1'b0, 1'b1, 32'hBEEF5A44);

    // Three wait states: handshake timing with req held high
    txn(1, "w3 store", 1'b1, SW, 32'h2004, 32'h0BADCAFE, 4, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("w3 ready t", 32'(ready[1]), 32'd1);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = SW; addr[1] = 32'h2004;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("w3 ready busy", 32'(ready[1]), 32'd0);
      chk("w3 rvalid", 32'(rvalid[1]), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("w3 rdata", rdata[1], 32'h0BADCAFE);
    chk("w3 err", 32'(err[1]), 32'd0);
    req[1] = 1'b0;
    @(negedge clk);
    chk("w3 ready t+5", 32'(ready[1]), 32'd1);
    chk("w3 rvalid t+5", 32'(rvalid[1]), 32'd0);
    chk("w3 rdata t+5", rdata[1], 32'd0);

    // Two wait states: reset in BUSY discards a pending store
    txn(2, "w2 store", 1'b1, SW, 32'h2010, 32'h12345678, 3, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = SW; addr[2] = 32'h2010; wdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    req[2] = 1'b0;
    chk("w2 ready busy", 32'(ready[2]), 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("w2 rst rvalid", 32'(rvalid[2]), 32'd0);
    chk("w2 rst ready", 32'(ready[2]), 32'd0);
    rst[2] = 1'b0;
    @(negedge clk);
    chk("w2 post ready", 32'(ready[2]), 32'd1);
    chk("w2 post rvalid", 32'(rvalid[2]), 32'd0);
    txn(2, "w2 ld prior", 1'b0, SW, 32'h2010, 32'h0, 3, 1'b0, 1'b1, 32'h12345678);

    // Reset landing on the commit edge wins
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; size[2] = SW; addr[2] = 32'h2010; wdata[2] = 32'hBAD0BAD0;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    chk("w2 commit rst rvalid", 32'(rvalid[2]), 32'd0);
    rst[2] = 1'b0;
    txn(2, "w2 ld after", 1'b0, SW, 32'h2010, 32'h0, 3, 1'b0, 1'b1, 32'h12345678);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
